// File: rtl/stream_min_max_tracker.sv
`default_nettype none
// ============================================================================
// Module   : stream_min_max_tracker
// Brief    : Per-frame min/max and rise/fall tracker over an unsigned sample
//            stream, with a valid/ready result handshake.
// Revision : 1.0
// ============================================================================
module stream_min_max_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               in_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   min_out,
    output logic [WIDTH-1:0]                   max_out,
    output logic [$clog2(FRAME_LEN+1)-1:0]     rise_cnt,
    output logic [$clog2(FRAME_LEN+1)-1:0]     fall_cnt,
    output logic                               smaller,
    output logic                               equal,
    output logic                               bigger
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   min_q, min_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rise_q, rise_d;
    logic [CNT_W-1:0]   fall_q, fall_d;
    logic               sm_q, sm_d;
    logic               eq_q, eq_d;
    logic               bg_q, bg_d;
    logic               w_accept;

    assign in_ready = (state_q != DONE);
    assign w_accept = in_valid && in_ready && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            sm_q    <= 1'b0;
            eq_q    <= 1'b0;
            bg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            sm_q    <= sm_d;
            eq_q    <= eq_d;
            bg_q    <= bg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        sm_d    = sm_q;
        eq_d    = eq_q;
        bg_d    = bg_q;

        if (clear) begin
            // Abort wins over everything, including a pending result handshake.
            state_d = IDLE;
            min_d   = '0;
            max_d   = '0;
            prev_d  = '0;
            cnt_d   = '0;
            rise_d  = '0;
            fall_d  = '0;
            sm_d    = 1'b0;
            eq_d    = 1'b0;
            bg_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        min_d   = in_data;
                        max_d   = in_data;
                        prev_d  = in_data;
                        cnt_d   = C_ONE;
                        rise_d  = '0;
                        fall_d  = '0;
                        sm_d    = 1'b0;
                        eq_d    = 1'b0;
                        bg_d    = 1'b0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        sm_d   = (in_data <  prev_q);
                        eq_d   = (in_data == prev_q);
                        bg_d   = (in_data >  prev_q);
                        if (in_data > prev_q) rise_d = rise_q + C_ONE;
                        if (in_data < prev_q) fall_d = fall_q + C_ONE;
                        if (in_data < min_q)  min_d  = in_data;
                        if (in_data > max_q)  max_d  = in_data;
                        prev_d = in_data;
                        cnt_d  = cnt_q + C_ONE;
                        if (cnt_q == C_LAST_CNT) state_d = DONE;
                    end
                end
                DONE: begin
                    // Results stay frozen until downstream takes them.
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == DONE);
    assign min_out   = min_q;
    assign max_out   = max_q;
    assign rise_cnt  = rise_q;
    assign fall_cnt  = fall_q;
    assign smaller   = sm_q;
    assign equal     = eq_q;
    assign bigger    = bg_q;

endmodule
`default_nettype wire
